// File: rtl/intc_pkg.sv
// Shared constants for the machine-level external interrupt controller.
// Register offsets, claim ID width and address decode helper.
package intc_pkg;

  localparam logic [3:0] INTC_PENDING = 4'h0;
  localparam logic [3:0] INTC_ENABLE  = 4'h4;
  localparam logic [3:0] INTC_CLAIM   = 4'h8;
  localparam logic [3:0] INTC_ACTIVE  = 4'hC;

  localparam int INTC_ID_W = 5;
  localparam logic [INTC_ID_W-1:0] INTC_ID_NONE = '0;

  // Byte offsets are word aligned; the low two bits never select.
  function automatic logic [3:0] reg_sel(input logic [3:0] addr);
    return addr & 4'hC;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder.
// Produces a 1-based source ID, or INTC_ID_NONE when the vector is empty.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0]      vec,
  output logic                 valid,
  output logic [INTC_ID_W-1:0] id
);

  assign valid = |vec;

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    id = INTC_ID_NONE;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) id = INTC_ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: edge latch, enable mask, claim/complete.
// Drives the registered int_req line toward the CSR register file.
module ext_int_ctrl
  import intc_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [3:0]      mmio_addr,
  input  logic            mmio_w_en,
  input  logic [31:0]     mmio_w_data,
  input  logic            mmio_r_en,
  output logic [31:0]     mmio_r_data,
  output logic            int_req
);

  localparam logic [NSRC-1:0] ONE = NSRC'(1);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] in_service;

  logic [NSRC-1:0] pending_n;
  logic [NSRC-1:0] enable_n;
  logic [NSRC-1:0] in_service_n;
  logic [31:0]     rdata_n;

  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] claim_onehot;
  logic [NSRC-1:0] clr_mask;
  logic [NSRC-1:0] done_mask;
  logic [NSRC-1:0] next_elig;
  logic [3:0]      sel;
  logic            rd_go;
  logic            wr_claim;
  logic            claim_valid;
  logic [INTC_ID_W-1:0] claim_id;
  logic            req_n;
  logic [INTC_ID_W-1:0] nxt_id_unused;

  assign src_edge     = irq_src & ~src_q;
  assign eligible     = pending & enable & ~in_service;
  assign claim_onehot = eligible & (~eligible + ONE);
  assign sel          = reg_sel(mmio_addr);
  assign rd_go        = mmio_r_en & ~mmio_w_en;
  assign wr_claim     = mmio_w_en && (sel == INTC_CLAIM);

  intc_prio_enc #(.NSRC(NSRC)) u_claim_enc (
    .vec   (eligible),
    .valid (claim_valid),
    .id    (claim_id)
  );

  // Next-state of the register file and read data for this access.
  always_comb begin
    clr_mask  = '0;
    done_mask = '0;
    rdata_n   = mmio_r_data;
    if (rd_go && sel == INTC_CLAIM && claim_valid)
      clr_mask = claim_onehot;
    for (int i = 0; i < NSRC; i++) begin
      done_mask[i] = wr_claim && in_service[i] &&
                     (mmio_w_data == 32'(i + 1));
    end
    pending_n    = (pending & ~clr_mask) | src_edge;
    in_service_n = (in_service & ~done_mask) | clr_mask;
    enable_n     = enable;
    if (mmio_w_en && sel == INTC_ENABLE)
      enable_n = mmio_w_data[NSRC-1:0];
    if (rd_go) begin
      unique case (sel)
        INTC_PENDING: rdata_n = 32'(pending);
        INTC_ENABLE:  rdata_n = 32'(enable);
        INTC_CLAIM:   rdata_n = 32'(claim_id);
        INTC_ACTIVE:  rdata_n = 32'(in_service);
        default:      rdata_n = '0;
      endcase
    end
  end

  assign next_elig = pending_n & enable_n & ~in_service_n;

  intc_prio_enc #(.NSRC(NSRC)) u_req_enc (
    .vec   (next_elig),
    .valid (req_n),
    .id    (nxt_id_unused)
  );

  // State register; reset also discards any access in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q       <= '0;
      pending     <= '0;
      enable      <= '0;
      in_service  <= '0;
      int_req     <= 1'b0;
      mmio_r_data <= '0;
    end else begin
      src_q       <= irq_src;
      pending     <= pending_n;
      enable      <= enable_n;
      in_service  <= in_service_n;
      int_req     <= req_n;
      mmio_r_data <= rdata_n;
    end
  end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are sampled there.
module tb_ext_int_ctrl;

  localparam int NSRC = 8;
  localparam logic [3:0] A_PEND = 4'h0;
  localparam logic [3:0] A_EN   = 4'h4;
  localparam logic [3:0] A_CLM  = 4'h8;
  localparam logic [3:0] A_ACT  = 4'hC;

  logic            clock = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_src;
  logic [3:0]      mmio_addr;
  logic            mmio_w_en;
  logic [31:0]     mmio_w_data;
  logic            mmio_r_en;
  logic [31:0]     mmio_r_data;
  logic            int_req;

  int n_vec = 0;
  int n_err = 0;

  ext_int_ctrl #(.NSRC(NSRC)) dut (
    .clock       (clock),
    .reset       (reset),
    .irq_src     (irq_src),
    .mmio_addr   (mmio_addr),
    .mmio_w_en   (mmio_w_en),
    .mmio_w_data (mmio_w_data),
    .mmio_r_en   (mmio_r_en),
    .mmio_r_data (mmio_r_data),
    .int_req     (int_req)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic exp);
    chk(tag, {31'b0, int_req}, {31'b0, exp});
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [31:0] exp);
    mmio_addr = a;
    mmio_r_en = 1'b1;
    tick();
    mmio_r_en = 1'b0;
    chk(tag, mmio_r_data, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    mmio_addr   = a;
    mmio_w_data = d;
    mmio_w_en   = 1'b1;
    tick();
    mmio_w_en   = 1'b0;
  endtask

  task automatic pulse(input logic [NSRC-1:0] s);
    irq_src = s;
    tick();
    irq_src = '0;
  endtask

  initial begin
    reset = 1'b1;
    irq_src = '0;
    mmio_addr = '0;
    mmio_w_en = 1'b0;
    mmio_w_data = '0;
    mmio_r_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_req("rst_req", 1'b0);
    chk("rst_rdata", mmio_r_data, 32'h0);
    rd("rst_pend", A_PEND, 32'h0);
    rd("rst_en", A_EN, 32'h0);
    rd("rst_act", A_ACT, 32'h0);

    // Single source: edge, claim, active
    wr(A_EN, 32'h05);
    chk_req("t1_req_idle", 1'b0);
    pulse(8'h04);
    chk_req("t1_req_hi", 1'b1);
    rd("t1_pend", A_PEND, 32'h04);
    rd("t1_claim", A_CLM, 32'd3);
    chk_req("t1_req_lo", 1'b0);
    rd("t1_act", A_ACT, 32'h04);
    rd("t1_pend2", A_PEND, 32'h00);

    // Two sources pending: lowest index first
    wr(A_EN, 32'h17);
    pulse(8'h12);
    chk_req("t2_req_hi", 1'b1);
    rd("t2_claim_a", A_CLM, 32'd2);
    chk_req("t2_req_still", 1'b1);
    rd("t2_claim_b", A_CLM, 32'd5);
    chk_req("t2_req_lo", 1'b0);
    rd("t2_claim_none", A_CLM, 32'd0);
    rd("t2_act", A_ACT, 32'h16);
    rd("t2_pend", A_PEND, 32'h00);
    wr(A_CLM, 32'd2);
    wr(A_CLM, 32'd3);
    wr(A_CLM, 32'd5);
    rd("t2_act_clr", A_ACT, 32'h00);

    // Re-edge while in service, then complete
    pulse(8'h01);
    chk_req("t3_req_hi", 1'b1);
    rd("t3_claim", A_CLM, 32'd1);
    chk_req("t3_req_lo", 1'b0);
    pulse(8'h01);
    chk_req("t3_req_masked", 1'b0);
    rd("t3_pend", A_PEND, 32'h01);
    wr(A_CLM, 32'd1);
    chk_req("t3_req_rereq", 1'b1);
    rd("t3_act", A_ACT, 32'h00);
    rd("t3_claim2", A_CLM, 32'd1);
    chk_req("t3_req_lo2", 1'b0);
    wr(A_CLM, 32'd1);
    rd("t3_act2", A_ACT, 32'h00);

    // Claim and new edge on the same source in one cycle
    wr(A_EN, 32'h08);
    pulse(8'h08);
    chk_req("t4_req_hi", 1'b1);
    tick();
    irq_src = 8'h08;
    mmio_addr = A_CLM;
    mmio_r_en = 1'b1;
    tick();
    mmio_r_en = 1'b0;
    irq_src = '0;
    chk("t4_claim", mmio_r_data, 32'd4);
    chk_req("t4_req_lo", 1'b0);
    rd("t4_pend", A_PEND, 32'h08);
    rd("t4_act", A_ACT, 32'h08);

    // Ignored writes and read/write collision
    wr(A_CLM, 32'd0);
    rd("t5_act_w0", A_ACT, 32'h08);
    wr(A_CLM, 32'd9);
    rd("t5_act_w9", A_ACT, 32'h08);
    wr(A_CLM, 32'd2);
    rd("t5_act_w2", A_ACT, 32'h08);
    wr(A_PEND, 32'hFF);
    rd("t5_pend_ro", A_PEND, 32'h08);
    rd("t5_act_pre", A_ACT, 32'h08);
    mmio_addr = A_EN;
    mmio_w_data = 32'hFFFF_FF3C;
    mmio_w_en = 1'b1;
    mmio_r_en = 1'b1;
    tick();
    mmio_w_en = 1'b0;
    mmio_r_en = 1'b0;
    chk("t5_rw_hold", mmio_r_data, 32'h08);
    rd("t5_en", A_EN, 32'h3C);
    chk_req("t5_req", 1'b0);

    // Reset mid-service, with accesses during reset
    reset = 1'b1;
    mmio_addr = A_CLM;
    mmio_r_en = 1'b1;
    tick();
    mmio_r_en = 1'b0;
    chk("t6_rdata", mmio_r_data, 32'h0);
    chk_req("t6_req", 1'b0);
    wr(A_EN, 32'hFF);
    reset = 1'b0;
    rd("t6_en", A_EN, 32'h0);
    rd("t6_pend", A_PEND, 32'h0);
    rd("t6_act", A_ACT, 32'h0);

    // Line held high through reset release
    irq_src = 8'h01;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("t7_pend_r", A_PEND, 32'h00);
    rd("t7_pend_s", A_PEND, 32'h01);
    wr(A_EN, 32'h01);
    chk_req("t7_req", 1'b1);
    rd("t7_claim", A_CLM, 32'd1);
    chk_req("t7_req_lo", 1'b0);
    irq_src = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ext_int_ctrl.md
# ext_int_ctrl

Machine-level external interrupt controller for core_v1. It latches rising edges on up to 31 peripheral interrupt lines and drives the single `int_req` line consumed by the CSR register file, which traps with mcause 0x8000000b. Firmware running at the trap vector reads CLAIM over a small MMIO port to get the winning source ID, services it, then writes the ID back to CLAIM to complete it.

## Interface
- `NSRC`, 8: number of interrupt sources, 1..31. Source i has ID i+1; ID 0 means "none".
- `clock` in 1: sole clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `irq_src` in NSRC: peripheral interrupt lines, synchronous to `clock`, rising-edge sensitive.
- `mmio_addr` in 4: byte offset 0x0/0x4/0x8/0xC; bits [1:0] ignored.
- `mmio_w_en` in 1: write strobe, one cycle per access.
- `mmio_w_data` in 32: write data.
- `mmio_r_en` in 1: read strobe, one cycle per access.
- `mmio_r_data` out 32: registered read data.
- `int_req` out 1: registered interrupt request to the CSR register file.

## Operation
- State: `src_q`, `pending`, `enable`, `in_service` (each NSRC bits), `int_req`, `mmio_r_data`.
- Reset: every one of these clears to 0.
  - Because `src_q` resets to 0, a line already high when reset deasserts counts as a rising edge on the first cycle after reset.
- Edge detect: `edge = irq_src & ~src_q`. `src_q <= irq_src` every cycle.
- Pending:
  - Set on edge, including while that source is in service.
  - Cleared only by a claim of that source.
  - A set and a clear in the same cycle: set wins.
- Eligible set: `pending & enable & ~in_service`.
- Winner: lowest index among the eligible set. ID = index+1, or 0 if the set is empty.
- Register map (reads return 0 in unused upper bits):
  - 0x0 PENDING: RO; writes ignored.
  - 0x4 ENABLE: RW; only bits [NSRC-1:0] stored.
  - 0x8 CLAIM:
    - Read returns the winner ID. If ID≠0, the winner's pending bit clears and its in_service bit sets.
    - Write with ID in 1..NSRC whose in_service bit is set clears that bit. Any other value is ignored.
  - 0xC ACTIVE: RO view of `in_service`.
- `int_req <= |eligible`, evaluated on the next-state values of pending, enable and in_service.
- Write and read strobes in the same cycle: the write is performed, the read is dropped, and `mmio_r_data` holds.
- Disabling a pending source keeps it pending. It becomes eligible again when re-enabled.

## Timing
- Read latency is 1 cycle.
  - With `mmio_r_en` high at edge k, `mmio_r_data` is valid after edge k and holds until the next read.
  - The claim side effect also takes place at edge k.
- Edge to request: `irq_src` rises before edge k → pending set at k → `int_req` high after edge k.
- Claim to drop: the claim read at edge k makes `int_req` low after edge k, provided no other source is eligible.
- Complete to re-request: a complete write at edge k for a source that is pending again → `int_req` high after edge k.
- `reset` asserted mid-operation: all state clears at that edge, including any claim in flight. `mmio_r_data` = 0.
- Accesses made while `reset` is high have no effect.

## Structure
- Package `intc_pkg`:
  - register offsets `INTC_PENDING`/`INTC_ENABLE`/`INTC_CLAIM`/`INTC_ACTIVE`;
  - `INTC_ID_W` = 5;
  - `INTC_ID_NONE` = 0.
- Sub-module `intc_prio_enc`:
  - combinational NSRC-bit vector → `valid` + ID;
  - lowest index wins;
  - used for both CLAIM read data and `int_req`.
- Top module holds edge detect, the registers and the MMIO decode.

## Test plan
- Reset, then ENABLE=0x05, pulse `irq_src[2]` → PENDING=0x04, `int_req` high one cycle after the pending edge; CLAIM reads 3; ACTIVE=0x04; `int_req` low.
- Sources 1 and 4 both pending and enabled → first CLAIM=2, `int_req` stays high; second CLAIM=5; third CLAIM=0 with no state change.
- In-service source 0 re-edges → PENDING bit 0 set, `int_req` stays low. Write CLAIM=1 → ACTIVE=0, `int_req` high one cycle later, next CLAIM=1.
- Claim read of source 3 in the same cycle as a new edge on source 3 → CLAIM=4, PENDING bit 3 remains 1, ACTIVE bit 3 = 1.
- Write CLAIM=0, CLAIM=9 with NSRC=8, and CLAIM of a non-active ID → all ignored. Write PENDING → ignored. Read and write strobes together → `mmio_r_data` unchanged.
- `irq_src[0]` held high through reset release → pending bit 0 set one cycle after reset deasserts. Assert `reset` mid-service → all registers, `int_req` and `mmio_r_data` zero.
